// File: rtl/uart_rx_if.sv
// uart_rx_if -- receive-side byte stream of the UART receiver.
//
// Handshake: a byte transfers on a rising clock edge where valid_o=1 and
// ready_i=1. Once valid_o rises, data_o is held stable and valid_o stays
// high until that transfer edge. ready_i has no effect while valid_o=0.
//
// Signals:
//   data_o      received byte, meaningful while valid_o=1
//   valid_o     byte available
//   ready_i     consumer accepts the byte
//   frame_err_o one-cycle pulse: stop bit sampled low, byte discarded
//   overrun_o   one-cycle pulse: completed byte dropped, holding register full
//   dbg_state   receiver FSM state (IDLE=0, START=1, DATA=2, STOP=3)
interface uart_rx_if;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic [1:0] dbg_state;

  modport master (
    output data_o, valid_o, frame_err_o, overrun_o, dbg_state,
    input  ready_i
  );

  modport slave (
    input  data_o, valid_o, frame_err_o, overrun_o, dbg_state,
    output ready_i
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with a one-byte holding register.
//
// Ports:
//   clk_i  single clock, all state on its rising edge
//   rst_i  asynchronous active-high reset
//   rx_i   asynchronous serial line, idle high, LSB first
//   bus    uart_rx_if.master: data_o/valid_o/ready_i stream plus the
//          frame_err_o and overrun_o pulses and the FSM debug state
//
// The line is synchronized with two flops; a falling edge of the
// synchronized line starts a frame. The start bit is re-checked half a bit
// later, then each data bit and the stop bit are sampled one full bit apart.
// The FSM leaves STOP at the stop-bit midpoint so back-to-back frames are
// caught.
module uart_rx #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD        = 115200
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      rx_i,
  uart_rx_if.master bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Counter is loaded with N-1 and expires when it reaches zero, so a load
  // of N-1 places the next sample exactly N cycles later.
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_rx: CLK_FREQ_HZ/BAUD must be at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Synchronizer and edge detector; all reset high so a quiet line after
  // reset never looks like an edge.
  logic r_sync1;
  logic r_rx_s;
  logic r_rx_prev;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx_i;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  logic w_fall;
  logic w_expired;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_frame_err;
  logic            r_overrun;

  assign w_fall    = r_rx_prev & ~r_rx_s;
  assign w_expired = (r_cnt == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= 3'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      // Consumer takes the held byte; a byte loading in STOP below
      // overrides this clear in the same cycle.
      if (r_valid && bus.ready_i) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state <= START;
            r_cnt   <= HALF_LOAD;
          end
        end

        START: begin
          if (w_expired) begin
            if (r_rx_s) begin
              // Line went back high before mid-start-bit: a glitch.
              r_state <= IDLE;
            end else begin
              r_state <= DATA;
              r_cnt   <= FULL_LOAD;
              r_idx   <= 3'd0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        DATA: begin
          if (w_expired) begin
            r_shift[r_idx] <= r_rx_s;
            r_cnt          <= FULL_LOAD;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= STOP;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        STOP: begin
          if (w_expired) begin
            r_state <= IDLE;
            if (!r_rx_s) begin
              r_frame_err <= 1'b1;
            end else if (!r_valid || bus.ready_i) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.data_o      = r_data;
  assign bus.valid_o     = r_valid;
  assign bus.frame_err_o = r_frame_err;
  assign bus.overrun_o   = r_overrun;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_rx_if bus();

  uart_rx #(
    .CLK_FREQ_HZ(16),
    .BAUD       (1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rx_i (rx),
    .bus  (bus)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ----------------------------------------------------------- bookkeeping
  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int beats  = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ scoreboard
  // Runs on the falling edge: a beat is valid_o & ready_i seen here, which
  // transfers on the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid_o && bus.ready_i) begin
        beats++;
        tests_run++;
        assert (exp_q.size() != 0) else begin
          tests_failed++;
          $error("FAIL unexpected_beat observed=%02h expected=none", bus.data_o);
        end
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          tests_run++;
          assert (bus.data_o === mon_exp) else begin
            tests_failed++;
            $error("FAIL beat_data observed=%02h expected=%02h", bus.data_o, mon_exp);
          end
        end
      end
      if (bus.frame_err_o === 1'b1) begin
        fe_cnt++;
        tests_run++;
        assert (fe_prev === 1'b0 && bus.overrun_o === 1'b0) else begin
          tests_failed++;
          $error("FAIL fe_pulse observed=prev%0b_ov%0b expected=prev0_ov0",
                 fe_prev, bus.overrun_o);
        end
      end
      if (bus.overrun_o === 1'b1) begin
        ov_cnt++;
        tests_run++;
        assert (ov_prev === 1'b0) else begin
          tests_failed++;
          $error("FAIL ov_pulse observed=prev%0b expected=prev0", ov_prev);
        end
      end
    end
    fe_prev = bus.frame_err_o;
    ov_prev = bus.overrun_o;
  end

  // --------------------------------------------------------------- drivers
  // Called right after a rising edge (+#1); leaves the line high at the
  // end of the stop bit, also right after a rising edge, so a following
  // call gives a stop bit of exactly 16 cycles.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(posedge clk);
      #1;
      rx = b[i];
    end
    repeat (16) @(posedge clk);
    #1;
    rx = stop_bit;
    repeat (16) @(posedge clk);
    #1;
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------- stimulus
  int  lat;
  logic seen;

  initial begin
    bus.ready_i = 1'b1;
    rst = 1'b1;
    rx  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data",  bus.data_o,      32'h00);
    check("rst_valid", bus.valid_o,     32'h0);
    check("rst_fe",    bus.frame_err_o, 32'h0);
    check("rst_ov",    bus.overrun_o,   32'h0);
    check("rst_state", bus.dbg_state,   32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);

    // 0xA5 with latency measurement from the line falling
    exp_q.push_back(8'hA5);
    lat  = 0;
    seen = 1'b0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        while (!seen && lat < 300) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          if (bus.valid_o === 1'b1) seen = 1'b1;
        end
      end
    join
    check("a5_latency", lat, 155);
    idle(4);
    @(negedge clk);
    check("a5_beats", beats,  1);
    check("a5_fe",    fe_cnt, 0);
    check("a5_ov",    ov_cnt, 0);
    check("a5_valid", bus.valid_o, 32'h0);

    // Short low glitch, then a good 0x3C
    idle(1);
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    @(negedge clk);
    check("glitch_beats", beats,  1);
    check("glitch_fe",    fe_cnt, 0);
    check("glitch_state", bus.dbg_state, 32'h0);
    idle(1);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    idle(4);
    @(negedge clk);
    check("3c_beats", beats, 2);

    // Stop bit low -> frame error, nothing delivered
    idle(1);
    send_byte(8'h3C, 1'b0);
    idle(4);
    @(negedge clk);
    check("ferr_count", fe_cnt, 1);
    check("ferr_beats", beats,  2);
    check("ferr_valid", bus.valid_o, 32'h0);

    // Overrun: hold 0x11, drop 0x22
    idle(1);
    bus.ready_i = 1'b0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(4);
    @(negedge clk);
    check("ovr_valid", bus.valid_o, 32'h1);
    check("ovr_data",  bus.data_o,  32'h11);
    check("ovr_count", ov_cnt, 1);
    check("ovr_beats", beats,  2);
    idle(1);
    bus.ready_i = 1'b1;
    idle(3);
    @(negedge clk);
    check("ovr_drain_valid", bus.valid_o, 32'h0);
    check("ovr_drain_beats", beats, 3);

    // Reset during data bit 3 of 0xFF
    idle(1);
    rx = 1'b0;
    idle(16);
    rx = 1'b1;
    idle(48 + 8);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_data",  bus.data_o,    32'h00);
    check("midrst_valid", bus.valid_o,   32'h0);
    check("midrst_state", bus.dbg_state, 32'h0);
    idle(3);
    rst = 1'b0;
    idle(200);
    @(negedge clk);
    check("midrst_fe",    fe_cnt, 1);
    check("midrst_ov",    ov_cnt, 1);
    check("midrst_beats", beats,  3);
    idle(1);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    idle(4);
    @(negedge clk);
    check("5a_beats", beats, 4);
    check("5a_data",  bus.data_o, 32'h5A);

    // Back-to-back 0x00 then 0xFF
    idle(1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(4);
    @(negedge clk);
    check("b2b_beats", beats,  6);
    check("b2b_fe",    fe_cnt, 1);
    check("b2b_ov",    ov_cnt, 1);
    check("b2b_data",  bus.data_o, 32'hFF);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
